// File: rtl/reset_sequencer.sv
// reset_sequencer
// Holds every downstream domain in reset for a programmable number of cycles,
// then releases the active-low channel resets one at a time. Each released
// channel gets a bounded window to raise its ready level before a stagger gap
// and the next release. A one-cycle software request replays the whole thing.
module reset_sequencer #(
    parameter int N_CH           = 4,
    parameter int CNT_W          = 16,
    parameter int HOLD_CYCLES    = 65535,
    parameter int STAGGER_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sw_rst_req,
    input  logic [N_CH-1:0] ch_ready,
    output logic [N_CH-1:0] rst_n,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] timeout_err
);

    // A single channel still needs a one-bit index so the datapath stays uniform.
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // The counter restarts from zero in every phase, so each phase ends when
    // the counter reaches its length minus one; it never has to wrap.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] cnt;
    logic             chan_ready;
    logic             chan_timeout;

    // Only the channel currently being waited on is looked at; any other
    // ready bit, even one that is already high, has no effect.
    assign idx_next     = idx + IDX_W'(1);
    assign chan_ready   = ch_ready[idx];
    assign chan_timeout = (cnt == TIMEOUT_LAST);

    // Sequencer: restart dominates everything, otherwise walk HOLD -> WAIT/GAP
    // pairs per channel -> DONE. Releases only ever OR bits into rst_n, so a
    // released channel stays released until the next restart.
    always_ff @(posedge clk) begin
        if (rst || sw_rst_req) begin
            state       <= S_HOLD;
            cnt         <= '0;
            idx         <= '0;
            rst_n       <= '0;
            timeout_err <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        rst_n <= rst_n | N_CH'(1);
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (chan_ready || chan_timeout) begin
                        // Ready arriving on the last allowed edge still counts
                        // as a clean acknowledge.
                        if (!chan_ready) begin
                            timeout_err <= timeout_err | (N_CH'(1) << idx);
                        end
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            cnt   <= '0;
                            state <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == STAGGER_LAST) begin
                        idx   <= idx_next;
                        rst_n <= rst_n | (N_CH'(1) << idx_next);
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed scenarios for the reset sequencer with N_CH=3, HOLD=16, STAGGER=4,
// TIMEOUT=32. Edge numbers are counted from E0 = 0, the first edge after a
// restart; expected edges are worked out by hand from the sequencing rules.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       sw_rst_req;
    logic [2:0] ch_ready;
    logic [2:0] rst_n;
    logic       busy;
    logic       done;
    logic [2:0] timeout_err;

    int tests_run;
    int tests_failed;

    // Observations gathered while a sequence runs (-1 means never seen).
    int rise_t[3];
    int err_t[3];
    int done_t;
    int busy_fall_t;
    int drops;

    reset_sequencer #(
        .N_CH          (3),
        .CNT_W         (16),
        .HOLD_CYCLES   (16),
        .STAGGER_CYCLES(4),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .ch_ready   (ch_ready),
        .rst_n      (rst_n),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge; inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle synchronous reset; the next edge is E0.
    task automatic restart_with_rst();
        ch_ready = 3'b000;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Run n_edges edges from E0. Channel i reports ready dly[i] edges after its
    // release (-1 = never) unless early[i] holds it high from the start.
    task automatic run_seq(input int d0, input int d1, input int d2,
                           input logic [2:0] early, input int n_edges);
        int         dly[3];
        logic [2:0] r;
        logic [2:0] prev;
        dly         = '{d0, d1, d2};
        done_t      = -1;
        busy_fall_t = -1;
        drops       = 0;
        for (int i = 0; i < 3; i++) begin
            rise_t[i] = -1;
            err_t[i]  = -1;
        end
        prev = rst_n;
        for (int k = 0; k < n_edges; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (early[i])
                    r[i] = 1'b1;
                else if (dly[i] >= 0 && rise_t[i] >= 0 && k >= rise_t[i] + dly[i])
                    r[i] = 1'b1;
                else
                    r[i] = 1'b0;
            end
            ch_ready = r;
            tick();
            for (int i = 0; i < 3; i++) begin
                if (rst_n[i] === 1'b1 && rise_t[i] < 0) rise_t[i] = k;
                if (timeout_err[i] === 1'b1 && err_t[i] < 0) err_t[i] = k;
            end
            if ((prev & ~rst_n) != 3'b000) drops++;
            prev = rst_n;
            if (done === 1'b1 && done_t < 0) done_t = k;
            if (busy === 1'b0 && busy_fall_t < 0) busy_fall_t = k;
        end
    endtask

    // Outputs must sit at their reset values every cycle rst is held.
    task automatic test_reset();
        rst        = 1'b1;
        sw_rst_req = 1'b0;
        ch_ready   = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run += 4;
            if (rst_n !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL reset rst_n cycle %0d: got %b, expected 000", c, rst_n);
            end
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset busy cycle %0d: got %b, expected 1", c, busy);
            end
            if (done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset done cycle %0d: got %b, expected 0", c, done);
            end
            if (timeout_err !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL reset err cycle %0d: got %b, expected 000", c, timeout_err);
            end
        end
        rst = 1'b0;
    endtask

    // Common checks for a completed run against hand-computed edges.
    task automatic check_run(input string name, input int e0, input int e1, input int e2,
                             input int exp_done, input logic [2:0] exp_err);
        int exp_rise[3];
        exp_rise = '{e0, e1, e2};
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rise_t[i] !== exp_rise[i]) begin
                tests_failed++;
                $display("[TB] FAIL %s rst_n[%0d] rise: got edge %0d, expected %0d",
                         name, i, rise_t[i], exp_rise[i]);
            end
        end
        tests_run += 5;
        if (done_t !== exp_done) begin
            tests_failed++;
            $display("[TB] FAIL %s done rise: got edge %0d, expected %0d", name, done_t, exp_done);
        end
        if (busy_fall_t !== exp_done) begin
            tests_failed++;
            $display("[TB] FAIL %s busy fall: got edge %0d, expected %0d", name, busy_fall_t, exp_done);
        end
        if (timeout_err !== exp_err) begin
            tests_failed++;
            $display("[TB] FAIL %s final err: got %b, expected %b", name, timeout_err, exp_err);
        end
        if (rst_n !== 3'b111 || done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s final state: got rst_n=%b done=%b, expected 111/1", name, rst_n, done);
        end
        if (drops !== 0) begin
            tests_failed++;
            $display("[TB] FAIL %s rst_n reassert: got %0d drops, expected 0", name, drops);
        end
    endtask

    // Ready 5 edges after each release: 15, 24, 33, done at 38.
    task automatic test_nominal();
        run_seq(5, 5, 5, 3'b000, 60);
        check_run("nominal", 15, 24, 33, 38, 3'b000);
    endtask

    // Channel 1 never ready: error at 24+32=56, channel 2 at 60, done at 65.
    task automatic test_timeout();
        restart_with_rst();
        run_seq(5, -1, 5, 3'b000, 80);
        check_run("timeout", 15, 24, 60, 65, 3'b010);
        tests_run++;
        if (err_t[1] !== 56) begin
            tests_failed++;
            $display("[TB] FAIL timeout err[1] rise: got edge %0d, expected 56", err_t[1]);
        end
    endtask

    // Channel 0 ready exactly on its timeout edge (47): clean acknowledge.
    task automatic test_ready_on_timeout_edge();
        restart_with_rst();
        run_seq(32, 5, 5, 3'b000, 80);
        check_run("edge_ready", 15, 51, 60, 65, 3'b000);
    endtask

    // All ready from the start: acknowledged on the first WAIT edge each time.
    task automatic test_early_ready();
        restart_with_rst();
        run_seq(0, 0, 0, 3'b111, 40);
        check_run("early", 15, 20, 25, 26, 3'b000);
    endtask

    // Pulse sw_rst_req and confirm the restart values one cycle later.
    task automatic pulse_sw(input string name);
        ch_ready   = 3'b000;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        tests_run += 2;
        if (rst_n !== 3'b000 || timeout_err !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL %s outputs: got rst_n=%b err=%b, expected 000/000",
                     name, rst_n, timeout_err);
        end
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s flags: got busy=%b done=%b, expected 1/0", name, busy, done);
        end
    endtask

    // Soft reset while waiting on channel 2 after channel 1 timed out, then
    // a full replay, then a soft reset from DONE and another replay.
    task automatic test_soft_reset();
        restart_with_rst();
        run_seq(5, -1, -1, 3'b000, 62);
        tests_run++;
        if (rise_t[2] !== 60 || err_t[1] !== 56 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL soft_pre state: got rise2=%0d err1=%0d done=%b, expected 60/56/0",
                     rise_t[2], err_t[1], done);
        end
        pulse_sw("soft_wait");
        run_seq(5, -1, 5, 3'b000, 80);
        check_run("soft_replay", 15, 24, 60, 65, 3'b010);
        pulse_sw("soft_done");
        run_seq(5, 5, 5, 3'b000, 60);
        check_run("soft_done_replay", 15, 24, 33, 38, 3'b000);
    endtask

    // Scenario order; every run is bounded by its edge count.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        sw_rst_req   = 1'b0;
        ch_ready     = 3'b000;
        test_reset();
        test_nominal();
        test_timeout();
        test_ready_on_timeout_edge();
        test_early_ready();
        test_soft_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised power-on / soft reset sequencer that holds every downstream domain in reset for a programmable count, then releases N_CH active-low channel resets one at a time. Each release waits for that channel's ready handshake, bounded by a timeout, before a stagger gap and the next release. It sits at the top of the system next to the clock source and feeds the per-subsystem rst_n inputs: CPU, memory controller, VGA, keyboard and so on. Beyond a simple power-on counter, it adds ordered release, a readiness handshake, timeout error flags and a software-triggered re-sequence.

## Interface
- N_CH, 4: number of reset channels; at least 1.
- CNT_W, 16: width of the shared cycle counter.
- HOLD_CYCLES, 65535: cycles all channels stay in reset after rst/sw_rst_req; at least 1 and below 2^CNT_W.
- STAGGER_CYCLES, 8: gap between one channel's ready and the next channel's release; at least 1 and below 2^CNT_W.
- TIMEOUT_CYCLES, 1024: maximum wait for ch_ready per channel; at least 1 and below 2^CNT_W.

- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sw_rst_req  in  1  one-cycle request to re-run the full sequence.
- ch_ready  in  N_CH  per-channel "initialised" level; bit i is sampled only while waiting on channel i.
- rst_n  out  N_CH  per-channel active-low reset; bit i is released before bit i+1.
- busy  out  1  high while the sequence is in progress.
- done  out  1  high once all channels are released and acknowledged or timed out.
- timeout_err  out  N_CH  sticky flag; bit i is set when channel i timed out.

## Operation
- States:
  - HOLD: all rst_n low; counter counts hold cycles.
  - WAIT: channel idx released; counter counts timeout.
  - GAP: counter counts stagger.
  - DONE: sequence complete.
- Registers: state, idx (channel index, clog2(N_CH) bits, minimum 1), cnt (CNT_W bits), rst_n, timeout_err.
- Restart condition is rst=1, or sw_rst_req=1 in any state. On restart, at the clock edge:
  - state=HOLD, cnt=0, idx=0;
  - rst_n all 0, timeout_err all 0;
  - busy=1, done=0.
  - rst has priority over sw_rst_req, but both produce the same result.
- HOLD:
  - If cnt==HOLD_CYCLES-1: rst_n[0]<=1, cnt<=0, go to WAIT.
  - Otherwise cnt<=cnt+1.
- WAIT: channel ready is taken when ch_ready[idx]==1, or when cnt==TIMEOUT_CYCLES-1 (timeout).
  - On timeout without ready, timeout_err[idx]<=1.
  - If ready and timeout occur on the same edge, ready wins and no error is flagged.
  - On ready or timeout:
    - if idx==N_CH-1, go to DONE (busy<=0, done<=1);
    - otherwise cnt<=0 and go to GAP.
  - Otherwise cnt<=cnt+1.
- GAP:
  - If cnt==STAGGER_CYCLES-1: idx<=idx+1, rst_n[idx+1]<=1, cnt<=0, go to WAIT.
  - Otherwise cnt<=cnt+1.
- DONE: hold all outputs until the next restart.
- Readiness is level-sensitive only: ch_ready of channels other than idx is ignored, including ones already high early.
- Once released, a channel's rst_n never re-asserts except on restart.
- The counter only ever compares for equality against a parameter and never wraps, given the parameter limits.

## Timing
- Reset values (cycle after rst=1): rst_n=0, busy=1, done=0, timeout_err=0.
- Edge E0 is the first edge with rst=0 and sw_rst_req=0.
- rst_n[0] rises on edge E0+HOLD_CYCLES-1, i.e. exactly HOLD_CYCLES edges counting E0.
- When ch_ready[i] is sampled high at edge Ek:
  - rst_n[i+1] rises at Ek+STAGGER_CYCLES;
  - if i is the last channel, done rises at Ek.
- If channel i is released at edge Er and never reports ready:
  - timeout_err[i] rises at Er+TIMEOUT_CYCLES;
  - the sequence then proceeds as if ready at that edge.
- A restart mid-sequence takes effect on the same edge: all rst_n drop in the following cycle and the sequence re-runs from HOLD.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
All scenarios use N_CH=3, HOLD=16, STAGGER=4, TIMEOUT=32.
- Reset: rst high for 3 cycles → rst_n=3'b000, busy=1, done=0, timeout_err=0 throughout.
- Nominal sequence: rst drops, ch_ready[i] goes high 5 cycles after rst_n[i] rises → rst_n[0] at E0+15, rst_n[1] 9 edges later, rst_n[2] 9 edges after that; done=1 and busy=0 on the edge ch_ready[2] is sampled.
- Timeout: ch_ready[1] held 0 → timeout_err=3'b010 exactly 32 edges after rst_n[1] rises; rst_n[2] follows 4 edges later; done=1 with err still 3'b010.
- Ready on the final timeout edge: ch_ready[0] rises on the 32nd edge of WAIT → no error, normal GAP follows.
- Early ready ignored: ch_ready=3'b111 from the start → each channel acknowledged on its first WAIT edge; rst_n[2] rises exactly at E0+15+5+5.
- Soft reset mid-WAIT on channel 2 after an error on channel 1: sw_rst_req pulse → next cycle rst_n=0, timeout_err=0, busy=1; full sequence replays with identical timing; a sw_rst_req pulse in DONE also replays it.
